pr_freelist: RTL

PR_FREELIST -- requirements
Module: pr_freelist

---
 rtl/pr_freelist_pkg.sv | 24 ++
 rtl/pr_freelist_fl_prefix4.sv | 27 ++
 rtl/pr_freelist.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pr_freelist_pkg.sv
// Shared constants and types for the physical-register free list.
package pr_freelist_pkg;

    localparam int PR_W         = 6;   // physical register index width
    localparam int PR_NUM       = 64;  // physical registers in the machine
    localparam int FL_DEPTH     = 32;  // free-list entries (PR_NUM minus architectural mappings)
    localparam int FL_PTR_W     = 6;   // ring index plus wrap bit
    localparam int FL_IDX_W     = FL_PTR_W - 1;
    localparam int FL_INIT_BASE = 32;  // first PR placed in the list after reset

    localparam int NUM_LANES    = 4;   // rename / commit / free width
    localparam int LANE_OFF_W   = 2;   // per-lane offset 0..3
    localparam int LANE_CNT_W   = 3;   // lane total 0..4

    typedef logic [PR_W-1:0]     pr_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;

    // Advance a ring pointer by a lane count; the wrap bit toggles naturally.
    function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input logic [LANE_CNT_W-1:0] n);
        return p + fl_ptr_t'(n);
    endfunction

endpackage

// File: rtl/pr_freelist_fl_prefix4.sv
// Exclusive prefix count over four enables: each lane learns how many
// lower-numbered lanes are active, and the total active count is reported.
module fl_prefix4
    import pr_freelist_pkg::*;
(
    input  logic [NUM_LANES-1:0]                 en,
    output logic [NUM_LANES-1:0][LANE_OFF_W-1:0] lane_off,
    output logic [LANE_CNT_W-1:0]                total
);

    genvar gi;

    // Lane 0 never has anyone ahead of it.
    assign lane_off[0] = '0;

    // Each lane's offset is its predecessor's offset plus the predecessor's enable;
    // the largest offset is 3, so the 2-bit adder never overflows.
    generate
        for (gi = 0; gi < NUM_LANES - 1; gi++) begin : g_chain
            assign lane_off[gi+1] = lane_off[gi] + LANE_OFF_W'(en[gi]);
        end
    endgenerate

    // Total is the last lane's offset plus its own enable (0..4).
    assign total = LANE_CNT_W'(lane_off[NUM_LANES-1]) + LANE_CNT_W'(en[NUM_LANES-1]);

endmodule

// File: rtl/pr_freelist.sv
// Physical-register free list for a 4-wide rename stage.
// Ring of FL_DEPTH PR indices with three pointers:
//   head        - next entry to hand out (speculative)
//   commit_head - next entry whose allocation has not yet committed
//   tail        - next slot to receive a freed PR
// A flush rewinds head to commit_head, returning every uncommitted
// allocation to the list without touching the stored entries.
module pr_freelist
    import pr_freelist_pkg::*;
#(
    parameter int PR_NUM   = pr_freelist_pkg::PR_NUM,
    parameter int FL_DEPTH = pr_freelist_pkg::FL_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_stage4,

    input  logic                       inst0_alloc_req,
    input  logic                       inst1_alloc_req,
    input  logic                       inst2_alloc_req,
    input  logic                       inst3_alloc_req,
    output logic [$clog2(PR_NUM)-1:0]  inst0_dest_PR,
    output logic [$clog2(PR_NUM)-1:0]  inst1_dest_PR,
    output logic [$clog2(PR_NUM)-1:0]  inst2_dest_PR,
    output logic [$clog2(PR_NUM)-1:0]  inst3_dest_PR,
    output logic                       alloc_stall,

    input  logic                       commit0_en,
    input  logic                       commit1_en,
    input  logic                       commit2_en,
    input  logic                       commit3_en,

    input  logic                       free0_en,
    input  logic                       free1_en,
    input  logic                       free2_en,
    input  logic                       free3_en,
    input  logic [$clog2(PR_NUM)-1:0]  free0_PR,
    input  logic [$clog2(PR_NUM)-1:0]  free1_PR,
    input  logic [$clog2(PR_NUM)-1:0]  free2_PR,
    input  logic [$clog2(PR_NUM)-1:0]  free3_PR,

    output logic [FL_PTR_W-1:0]        free_count
);

    genvar gi;

    // Tail starts one full lap ahead of head: every entry is free after reset.
    localparam fl_ptr_t TAIL_RESET = fl_ptr_t'(FL_DEPTH);

    // ------------------------------------------------------------------
    // Lane bundling
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] alloc_req;
    logic [NUM_LANES-1:0] commit_en;
    logic [NUM_LANES-1:0] free_en;
    pr_t                  free_pr [NUM_LANES];
    pr_t                  dest_pr [NUM_LANES];

    assign alloc_req = {inst3_alloc_req, inst2_alloc_req, inst1_alloc_req, inst0_alloc_req};
    assign commit_en = {commit3_en, commit2_en, commit1_en, commit0_en};
    assign free_en   = {free3_en, free2_en, free1_en, free0_en};

    assign free_pr[0] = free0_PR;
    assign free_pr[1] = free1_PR;
    assign free_pr[2] = free2_PR;
    assign free_pr[3] = free3_PR;

    assign inst0_dest_PR = dest_pr[0];
    assign inst1_dest_PR = dest_pr[1];
    assign inst2_dest_PR = dest_pr[2];
    assign inst3_dest_PR = dest_pr[3];

    // ------------------------------------------------------------------
    // Lane compaction: requests, commits and frees need not be contiguous,
    // so each active lane is packed against the lanes below it.
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0][LANE_OFF_W-1:0] alloc_off;
    logic [NUM_LANES-1:0][LANE_OFF_W-1:0] free_off;
    // Commits only move commit_head by their count; per-lane positions are not needed.
    logic [NUM_LANES-1:0][LANE_OFF_W-1:0] commit_off_unused;
    logic [LANE_CNT_W-1:0]                alloc_total;
    logic [LANE_CNT_W-1:0]                free_total;
    logic [LANE_CNT_W-1:0]                commit_total;

    fl_prefix4 u_alloc_prefix (
        .en       (alloc_req),
        .lane_off (alloc_off),
        .total    (alloc_total)
    );

    fl_prefix4 u_free_prefix (
        .en       (free_en),
        .lane_off (free_off),
        .total    (free_total)
    );

    fl_prefix4 u_commit_prefix (
        .en       (commit_en),
        .lane_off (commit_off_unused),
        .total    (commit_total)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    fl_ptr_t head_reg,        head_next;
    fl_ptr_t commit_head_reg, commit_head_next;
    fl_ptr_t tail_reg,        tail_next;
    logic    alloc_stall_w;

    // Wrap-bit pointers make a full list (32) distinguishable from an empty one (0).
    assign free_count = tail_reg - head_reg;

    // All-or-nothing grant: stall whenever the group asks for more than is free.
    assign alloc_stall_w = (fl_ptr_t'(alloc_total) > free_count);
    assign alloc_stall   = alloc_stall_w;

    // Next-pointer selection: flush rewinds head past this cycle's commits,
    // otherwise head moves only on a full grant.
    always_comb begin
        commit_head_next = ptr_add(commit_head_reg, commit_total);
        tail_next        = ptr_add(tail_reg, free_total);
        head_next        = head_reg;
        if (flush_stage4) begin
            head_next = commit_head_next;
        end else if (!alloc_stall_w) begin
            head_next = ptr_add(head_reg, alloc_total);
        end
    end

    // Pointer registers; reset returns to a completely full list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg        <= '0;
            commit_head_reg <= '0;
            tail_reg        <= TAIL_RESET;
        end else begin
            head_reg        <= head_next;
            commit_head_reg <= commit_head_next;
            tail_reg        <= tail_next;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Needs four combinational read ports and four write
    // ports per cycle plus a defined reset image, so it is a flop array
    // rather than a block RAM.
    // ------------------------------------------------------------------
    pr_t     entry_q   [FL_DEPTH];
    fl_idx_t free_slot [NUM_LANES];

    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            // Free lanes write consecutive slots starting at tail.
            assign free_slot[gi] = tail_reg[FL_IDX_W-1:0] + fl_idx_t'(free_off[gi]);

            // Read straight from the array: a PR freed this cycle is not
            // visible to rename until the write lands at the next edge.
            assign dest_pr[gi] = entry_q[head_reg[FL_IDX_W-1:0] + fl_idx_t'(alloc_off[gi])];
        end

        for (gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
            logic entry_we;
            pr_t  entry_next;
            pr_t  entry_reg;

            // Slot write select: active free lanes target distinct slots, so at most one matches.
            always_comb begin
                entry_we   = 1'b0;
                entry_next = entry_reg;
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (free_en[k] && (free_slot[k] == fl_idx_t'(gi))) begin
                        entry_we   = 1'b1;
                        entry_next = free_pr[k];
                    end
                end
            end

            // Entry register; reset loads the PRs that are not architecturally mapped.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= pr_t'(FL_INIT_BASE + gi);
                end else if (entry_we) begin
                    entry_reg <= entry_next;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule
